// File: rtl/video_pkg.sv
// Shared constants and types for the raster timing path (640x480@60 defaults).
package video_pkg;

   localparam int CNT_W = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam bit SYNC_ACTIVE_LOW = 1'b0;

   typedef logic [23:0] rgb888_t;

endpackage

// File: rtl/video_timing_raster_counter.sv
// Wrapping counter with active-region and sync-window decode; used for both h and v.
module raster_counter
   import video_pkg::*;
#(
   parameter int TOTAL      = 800,
   parameter int ACTIVE     = 640,
   parameter int SYNC_START = 656,
   parameter int SYNC_LEN   = 96
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_last,
   output logic             o_wrap,
   output logic             o_active,
   output logic             o_sync
);

   localparam logic [CNT_W-1:0] LAST_VAL   = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] ACTIVE_VAL = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(SYNC_START);
   localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_START + SYNC_LEN - 1);

   logic [CNT_W-1:0] r_cnt;

   // Count when enabled, return to 0 after the last position.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (r_cnt == LAST_VAL) r_cnt <= '0;
         else                   r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt    = r_cnt;
   assign o_last   = (r_cnt == LAST_VAL);
   assign o_wrap   = i_en && (r_cnt == LAST_VAL);
   assign o_active = (r_cnt < ACTIVE_VAL);
   assign o_sync   = (r_cnt >= SYNC_FIRST) && (r_cnt <= SYNC_LAST);

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: stage 0 counters, stage 1 ppu strobes, stage 2 display outputs.
// There is no handshake: i_pixel arrives one cycle after o_rd (ppu registered response),
// so it lines up with stage 2 and is gated by the stage-2 active flag without backpressure.
module video_timing
   import video_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
   input  logic        clk,
   input  logic        i_rst,
   input  rgb888_t     i_pixel,
   output logic        o_rd,
   output logic        o_newline,
   output logic        o_newframe,
   output logic [9:0]  o_x,
   output logic [9:0]  o_y,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output rgb888_t     o_rgb,
   output logic [7:0]  o_frame
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic [CNT_W-1:0] w_h, w_v;
   logic w_h_last, w_h_wrap, w_h_act, w_h_sync;
   logic w_v_last, w_v_wrap, w_v_act, w_v_sync;
   logic w_nf_cond, w_nl_cond;

   raster_counter #(
      .TOTAL(H_TOT), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC)
   ) u_h (
      .clk(clk), .i_rst(i_rst), .i_en(1'b1),
      .o_cnt(w_h), .o_last(w_h_last), .o_wrap(w_h_wrap), .o_active(w_h_act), .o_sync(w_h_sync)
   );

   raster_counter #(
      .TOTAL(V_TOT), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC)
   ) u_v (
      .clk(clk), .i_rst(i_rst), .i_en(w_h_wrap),
      .o_cnt(w_v), .o_last(w_v_last), .o_wrap(w_v_wrap), .o_active(w_v_act), .o_sync(w_v_sync)
   );

   // Newline and newframe are mutually exclusive: the last line only raises newframe.
   assign w_nf_cond = w_h_last && w_v_last;
   assign w_nl_cond = w_h_last && !w_v_last;

   logic       r_rd, r_nl, r_nf, r_hs1, r_vs1;
   logic [9:0] r_x, r_y;
   logic [7:0] r_frame;

   // Stage 1: registered decode of the counters; frame count steps with newframe.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_rd    <= 1'b0;
         r_nl    <= 1'b0;
         r_nf    <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_hs1   <= 1'b0;
         r_vs1   <= 1'b0;
         r_frame <= '0;
      end else begin
         r_rd  <= w_h_act && w_v_act;
         r_nl  <= w_nl_cond;
         r_nf  <= w_nf_cond;
         r_x   <= w_h;
         r_y   <= w_v;
         r_hs1 <= w_h_sync;
         r_vs1 <= w_v_sync;
         if (w_nf_cond) r_frame <= r_frame + 8'd1;
      end
   end

   logic r_de, r_hsync, r_vsync;

   // Stage 2: data enable and syncs delayed one more cycle to meet the ppu pixel.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_de    <= 1'b0;
         r_hsync <= !SYNC_POL;
         r_vsync <= !SYNC_POL;
      end else begin
         r_de    <= r_rd;
         r_hsync <= r_hs1 ? SYNC_POL : !SYNC_POL;
         r_vsync <= r_vs1 ? SYNC_POL : !SYNC_POL;
      end
   end

   assign o_rd       = r_rd;
   assign o_newline  = r_nl;
   assign o_newframe = r_nf;
   assign o_x        = r_x;
   assign o_y        = r_y;
   assign o_frame    = r_frame;
   assign o_de       = r_de;
   assign o_hsync    = r_hsync;
   assign o_vsync    = r_vsync;
   assign o_rgb      = r_de ? i_pixel : '0;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing using a reduced raster so full frames and frame wrap stay short.
module tb_video_timing;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int HT = 15;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VT = 8;
  localparam int FT = HT * VT;   // 120 cycles per frame
  localparam logic POL = 1'b0;
  localparam logic [23:0] PIX = 24'h716AB8;

  logic        clk;
  logic        i_rst;
  logic [23:0] i_pixel;
  logic        o_rd, o_newline, o_newframe, o_hsync, o_vsync, o_de;
  logic [9:0]  o_x, o_y;
  logic [23:0] o_rgb;
  logic [7:0]  o_frame;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_pixel(i_pixel),
    .o_rd(o_rd), .o_newline(o_newline), .o_newframe(o_newframe),
    .o_x(o_x), .o_y(o_y), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_de(o_de), .o_rgb(o_rgb), .o_frame(o_frame)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // expected-value model indexed by cycle since reset release (cycle 0 has h=v=0)
  function automatic logic e_rd(int c);
    if (c < 1) return 1'b0;
    return (((c - 1) % HT) < HA) && ((((c - 1) / HT) % VT) < VA);
  endfunction

  function automatic logic [9:0] e_x(int c);
    if (c < 1) return 10'd0;
    return 10'((c - 1) % HT);
  endfunction

  function automatic logic [9:0] e_y(int c);
    if (c < 1) return 10'd0;
    return 10'(((c - 1) / HT) % VT);
  endfunction

  function automatic logic e_nl(int c);
    if (c < 1) return 1'b0;
    return (((c - 1) % HT) == HT - 1) && ((((c - 1) / HT) % VT) != VT - 1);
  endfunction

  function automatic logic e_nf(int c);
    if (c < 1) return 1'b0;
    return (((c - 1) % HT) == HT - 1) && ((((c - 1) / HT) % VT) == VT - 1);
  endfunction

  function automatic logic [7:0] e_frame(int c);
    return 8'(c / FT);
  endfunction

  function automatic logic e_de(int c);
    if (c < 2) return 1'b0;
    return (((c - 2) % HT) < HA) && ((((c - 2) / HT) % VT) < VA);
  endfunction

  function automatic logic e_hs(int c);
    int h;
    if (c < 2) return !POL;
    h = (c - 2) % HT;
    return (h >= HA + HF && h < HA + HF + HS) ? POL : !POL;
  endfunction

  function automatic logic e_vs(int c);
    int v;
    if (c < 2) return !POL;
    v = ((c - 2) / HT) % VT;
    return (v >= VA + VF && v < VA + VF + VS) ? POL : !POL;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step();
    step();
    n_cmp++; if (o_rd !== 1'b0)       begin n_bad++; $display("FAIL reset_rd got=%b exp=0", o_rd); end
    n_cmp++; if (o_newline !== 1'b0)  begin n_bad++; $display("FAIL reset_newline got=%b exp=0", o_newline); end
    n_cmp++; if (o_newframe !== 1'b0) begin n_bad++; $display("FAIL reset_newframe got=%b exp=0", o_newframe); end
    n_cmp++; if (o_de !== 1'b0)       begin n_bad++; $display("FAIL reset_de got=%b exp=0", o_de); end
    n_cmp++; if (o_x !== 10'd0)       begin n_bad++; $display("FAIL reset_x got=%0d exp=0", o_x); end
    n_cmp++; if (o_y !== 10'd0)       begin n_bad++; $display("FAIL reset_y got=%0d exp=0", o_y); end
    n_cmp++; if (o_rgb !== 24'd0)     begin n_bad++; $display("FAIL reset_rgb got=%h exp=0", o_rgb); end
    n_cmp++; if (o_frame !== 8'd0)    begin n_bad++; $display("FAIL reset_frame got=%0d exp=0", o_frame); end
    n_cmp++; if (o_hsync !== 1'b1)    begin n_bad++; $display("FAIL reset_hsync got=%b exp=1", o_hsync); end
    n_cmp++; if (o_vsync !== 1'b1)    begin n_bad++; $display("FAIL reset_vsync got=%b exp=1", o_vsync); end
  endtask

  // Two full frames from release, every output checked each cycle, plus event counts.
  task automatic test_frames();
    int nl_cnt = 0;
    int first_nl = -1;
    int first_nf = -1;
    release_reset();
    while (1) begin
      n_cmp++; if (o_rd !== e_rd(cyc))         begin n_bad++; $display("FAIL frm_rd c=%0d got=%b exp=%b", cyc, o_rd, e_rd(cyc)); end
      n_cmp++; if (o_x !== e_x(cyc))           begin n_bad++; $display("FAIL frm_x c=%0d got=%0d exp=%0d", cyc, o_x, e_x(cyc)); end
      n_cmp++; if (o_y !== e_y(cyc))           begin n_bad++; $display("FAIL frm_y c=%0d got=%0d exp=%0d", cyc, o_y, e_y(cyc)); end
      n_cmp++; if (o_newline !== e_nl(cyc))    begin n_bad++; $display("FAIL frm_nl c=%0d got=%b exp=%b", cyc, o_newline, e_nl(cyc)); end
      n_cmp++; if (o_newframe !== e_nf(cyc))   begin n_bad++; $display("FAIL frm_nf c=%0d got=%b exp=%b", cyc, o_newframe, e_nf(cyc)); end
      n_cmp++; if (o_frame !== e_frame(cyc))   begin n_bad++; $display("FAIL frm_cnt c=%0d got=%0d exp=%0d", cyc, o_frame, e_frame(cyc)); end
      n_cmp++; if (o_de !== e_de(cyc))         begin n_bad++; $display("FAIL frm_de c=%0d got=%b exp=%b", cyc, o_de, e_de(cyc)); end
      n_cmp++; if (o_hsync !== e_hs(cyc))      begin n_bad++; $display("FAIL frm_hs c=%0d got=%b exp=%b", cyc, o_hsync, e_hs(cyc)); end
      n_cmp++; if (o_vsync !== e_vs(cyc))      begin n_bad++; $display("FAIL frm_vs c=%0d got=%b exp=%b", cyc, o_vsync, e_vs(cyc)); end
      n_cmp++; if (o_rgb !== (e_de(cyc) ? PIX : 24'd0))
        begin n_bad++; $display("FAIL frm_rgb c=%0d got=%h exp=%h", cyc, o_rgb, e_de(cyc) ? PIX : 24'd0); end
      if (cyc >= 1 && cyc <= FT && o_newline === 1'b1) begin
        nl_cnt++;
        if (first_nl < 0) first_nl = cyc;
      end
      if (o_newframe === 1'b1 && first_nf < 0) first_nf = cyc;
      if (cyc == 2 * FT + 3) break;
      step();
    end
    n_cmp++; if (nl_cnt != 7)    begin n_bad++; $display("FAIL nl_count got=%0d exp=7", nl_cnt); end
    n_cmp++; if (first_nl != 15) begin n_bad++; $display("FAIL first_nl got=%0d exp=15", first_nl); end
    n_cmp++; if (first_nf != 120) begin n_bad++; $display("FAIL first_nf got=%0d exp=120", first_nf); end
  endtask

  // Reset asserted at h=5, v=2 for 3 cycles; then the raster restarts like a fresh release.
  task automatic test_mid_reset();
    release_reset();
    while (cyc < 2 * HT + 5) step();
    i_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (o_rd !== 1'b0 || o_de !== 1'b0 || o_newline !== 1'b0 || o_newframe !== 1'b0)
        begin n_bad++; $display("FAIL mid_rst_ctl k=%0d got rd=%b de=%b nl=%b nf=%b exp=0", k, o_rd, o_de, o_newline, o_newframe); end
      n_cmp++; if (o_x !== 10'd0 || o_y !== 10'd0 || o_rgb !== 24'd0 || o_frame !== 8'd0)
        begin n_bad++; $display("FAIL mid_rst_data k=%0d got x=%0d y=%0d rgb=%h f=%0d exp=0", k, o_x, o_y, o_rgb, o_frame); end
      n_cmp++; if (o_hsync !== 1'b1 || o_vsync !== 1'b1)
        begin n_bad++; $display("FAIL mid_rst_sync k=%0d got hs=%b vs=%b exp=1", k, o_hsync, o_vsync); end
    end
    i_rst = 1'b0;
    cyc = 0;
    while (1) begin
      n_cmp++; if (o_rd !== e_rd(cyc))      begin n_bad++; $display("FAIL rst_rd c=%0d got=%b exp=%b", cyc, o_rd, e_rd(cyc)); end
      n_cmp++; if (o_de !== e_de(cyc))      begin n_bad++; $display("FAIL rst_de c=%0d got=%b exp=%b", cyc, o_de, e_de(cyc)); end
      n_cmp++; if (o_x !== e_x(cyc))        begin n_bad++; $display("FAIL rst_x c=%0d got=%0d exp=%0d", cyc, o_x, e_x(cyc)); end
      n_cmp++; if (o_y !== 10'd0)           begin n_bad++; $display("FAIL rst_y c=%0d got=%0d exp=0", cyc, o_y); end
      n_cmp++; if (o_newline !== e_nl(cyc)) begin n_bad++; $display("FAIL rst_nl c=%0d got=%b exp=%b", cyc, o_newline, e_nl(cyc)); end
      n_cmp++; if (o_hsync !== e_hs(cyc))   begin n_bad++; $display("FAIL rst_hs c=%0d got=%b exp=%b", cyc, o_hsync, e_hs(cyc)); end
      if (cyc == HT) break;
      step();
    end
  endtask

  // 256 frames: frame counter value at each newframe, wrapping 255 -> 0 on the last.
  task automatic test_frame_wrap();
    int t;
    release_reset();
    for (int k = 1; k <= 256; k++) begin
      t = 0;
      do begin
        step();
        t++;
      end while (o_newframe !== 1'b1 && t < FT + 5);
      if (o_newframe !== 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL wrap_timeout frame=%0d got=no_newframe exp=newframe", k);
        break;
      end
      n_cmp++; if (cyc != k * FT) begin n_bad++; $display("FAIL wrap_period k=%0d got=%0d exp=%0d", k, cyc, k * FT); end
      n_cmp++; if (o_frame !== 8'(k)) begin n_bad++; $display("FAIL wrap_frame k=%0d got=%0d exp=%0d", k, o_frame, 8'(k)); end
    end
    n_cmp++; if (o_frame !== 8'd0) begin n_bad++; $display("FAIL wrap_final got=%0d exp=0", o_frame); end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_pixel = PIX;
    test_reset();
    test_frames();
    test_mid_reset();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing.md
# video_timing

Raster timing generator and pixel scan-out stage directly downstream of the `ppu` core. It owns the horizontal and vertical counters and drives the `ppu` pacing strobes: `o_rd` feeds `i_rd`, `o_newline` feeds `i_newline`, and `o_newframe` feeds `i_newframe`. It captures the `ppu` pixel output and re-aligns it with display sync and data-enable for the video encoder.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 33: vertical back porch
- `SYNC_POL`, 0: active level of hsync and vsync (0 = active-low)

Ports:
- `clk` in 1: pixel clock; the only clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_pixel` in 24: RGB888 from `ppu` `o_pixel`; valid the cycle after `o_rd`.
- `o_rd` out 1: request pixel; high for each active (h,v).
- `o_newline` out 1: one-cycle pulse at end of every line except the last line of the frame.
- `o_newframe` out 1: one-cycle pulse at end of frame.
- `o_x` out 10: h counter value corresponding to `o_rd`.
- `o_y` out 10: v counter value corresponding to `o_rd`.
- `o_hsync` out 1: horizontal sync, aligned with `o_rgb`.
- `o_vsync` out 1: vertical sync, aligned with `o_rgb`.
- `o_de` out 1: data enable, aligned with `o_rgb`.
- `o_rgb` out 24: pixel out; 0 when `o_de`=0.
- `o_frame` out 8: frame counter; wraps 255→0.

## Operation
- `H_TOTAL` = sum of the H params (800); `V_TOTAL` = sum of the V params (525).
- Counter `h`: 0..H_TOTAL-1, wraps to 0.
- Counter `v`: increments when `h` wraps; wraps 0 after V_TOTAL-1.
- Stage 0: counters.
- Stage 1 (registered decode of stage 0):
  - `o_rd` = (h<H_ACTIVE) && (v<V_ACTIVE)
  - `o_x`=h, `o_y`=v
  - `o_newframe` = (h==H_TOTAL-1) && (v==V_TOTAL-1)
  - `o_newline` = (h==H_TOTAL-1) && !newframe-condition
  - `o_newline` and `o_newframe` are never high together.
- Stage 2 (registered from stage 1):
  - `o_de` = stage-1 active
  - hsync active while h ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vsync active while v ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
  - `o_rgb` = stage-1 active ? `i_pixel` : 0
- `o_frame` increments in the same cycle `o_newframe` is asserted.
- Reset (any cycle, including mid-line or mid-frame):
  - h=v=0
  - `o_rd`, `o_newline`, `o_newframe`, `o_de` = 0
  - `o_x`, `o_y`, `o_rgb`, `o_frame` = 0
  - `o_hsync` = `o_vsync` = !SYNC_POL (inactive)
  - Pipeline contents are discarded. There is no partial-frame completion; the raster restarts at (0,0).

## Timing
- Cycle 0 = first cycle with `i_rst` low; h=0, v=0 in that cycle.
- Stage-1 outputs lag the counters by 1 cycle; stage-2 outputs lag by 2 cycles.
- `o_de` is exactly `o_rd` delayed 1 cycle. This matches the 1-cycle registered response of `ppu`.
- Line period is H_TOTAL cycles and frame period is H_TOTAL·V_TOTAL cycles, with no variation.
- `o_newframe` is followed one cycle later by (h,v)=(0,0) decoded in stage 1. The `ppu` therefore sees its coordinate reset before the first `o_rd` of the next frame.
- No handshake or backpressure: `i_pixel` is sampled unconditionally in stage 2 and gated by active.

## Structure
- Shared package `video_pkg`:
  - default timing constants for 640x480@60
  - `H_TOTAL`, `V_TOTAL` localparam formulas
  - `rgb888_t` typedef (24 bits)
  - `SYNC_ACTIVE_LOW` constant
- Sub-module `raster_counter`: parameterised wrapping counter with `i_en`, `o_wrap` and a sync-window decode. Instantiated twice, for h and for v (v enabled by the h wrap).

## Test plan
- Release reset at cycle 0 → `o_rd` high cycles 1..640; `o_de` high cycles 2..641; `o_x`=0 at cycle 1 and `o_x`=639 at cycle 640.
- Same run → `o_hsync` low cycles 658..753 (SYNC_POL=0); first `o_newline` pulse at cycle 800, single cycle.
- Full frame → exactly 524 `o_newline` pulses, then `o_newframe` at cycle 420000 with no `o_newline` that cycle; `o_frame` 0→1; `o_vsync` low for v=490..491 (2 lines).
- Drive `i_pixel`=24'h716AB8 constantly → `o_rgb`=716AB8 exactly when `o_de`=1, 0 elsewhere (blanking, porches).
- Assert `i_rst` at h=300, v=100 for 3 cycles → all outputs at reset values during reset; after release, timing is identical to the first test (first `o_rd` at cycle 1).
- Run 256 frames → `o_frame` wraps 255→0 on the 256th `o_newframe`.
